// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: two-requester memory sequencer driving the shared MAR.
// Each transaction walks IDLE -> LOAD -> XFER -> ACCESS -> RESP. A round-robin
// bit decides ties between the fetch and load/store ports. Every output is a
// register except busy, which is decoded from the state.
module mem_access_ctrl #(
    parameter int AW   = 13,
    parameter int DW   = 16,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic [DW-1:0] ls_rdata,
    output logic          mar_wr_en,
    output logic [AW-1:0] mar_in,
    output logic          mar_re_en,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, LOAD, XFER, ACCESS, RESP} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t        state;
    logic [3:0]    cnt;
    logic          owner_ls;   // 1 = load/store owns the current transaction
    logic          last_ls;    // 1 = load/store won the most recent grant
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic          grant_ls;

    // Round-robin pick: a lone requester wins, and a tie goes to the side that did not win last.
    always_comb begin
        grant_ls = ls_req && (!if_req || !last_ls);
    end

    assign busy = (state != IDLE);

    // Transaction sequencer. Outputs are set one edge early, so each one is valid during its own state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            owner_ls  <= 1'b0;
            last_ls   <= 1'b1;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            mar_wr_en <= 1'b0;
            mar_in    <= '0;
            mar_re_en <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            if_ack <= 1'b0;
            ls_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || ls_req) begin
                        owner_ls  <= grant_ls;
                        last_ls   <= grant_ls;
                        we_q      <= grant_ls && ls_we;
                        wdata_q   <= grant_ls ? ls_wdata : '0;
                        mar_in    <= grant_ls ? ls_addr : if_addr;
                        mar_wr_en <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    mar_wr_en <= 1'b0;
                    mar_re_en <= 1'b1;
                    state     <= XFER;
                end
                XFER: begin
                    mar_re_en <= 1'b0;
                    cnt       <= 4'd0;
                    mem_rd    <= !we_q;
                    mem_wr    <= we_q;
                    mem_wdata <= wdata_q;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == WAIT_CNT) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (!we_q) begin
                            if (owner_ls) ls_rdata <= mem_rdata;
                            else          if_rdata <= mem_rdata;
                        end
                        if_ack <= !owner_ls;
                        ls_ack <= owner_ls;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus a randomized two-port run
// checked against a transaction-level memory model.
module tb_mem_access_ctrl;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int WAIT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [AW-1:0] if_addr = '0, ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          if_ack, ls_ack, mar_wr_en, mar_re_en, mem_rd, mem_wr, busy;
    logic [DW-1:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mar_in;

    mem_access_ctrl #(.AW(AW), .DW(DW), .WAIT(WAIT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mar_wr_en(mar_wr_en), .mar_in(mar_in), .mar_re_en(mar_re_en),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Second instance with no extra wait cycles.
    logic          z_if_req = 1'b0, z_ls_req = 1'b0, z_ls_we = 1'b0;
    logic [AW-1:0] z_if_addr = '0, z_ls_addr = '0;
    logic [DW-1:0] z_ls_wdata = '0;
    logic          z_if_ack, z_ls_ack, z_mar_wr_en, z_mar_re_en, z_mem_rd, z_mem_wr, z_busy;
    logic [DW-1:0] z_if_rdata, z_ls_rdata, z_mem_wdata;
    logic [DW-1:0] z_mem_rdata = 16'h1234;
    logic [AW-1:0] z_mar_in;

    mem_access_ctrl #(.AW(AW), .DW(DW), .WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_rdata(z_if_rdata),
        .ls_req(z_ls_req), .ls_we(z_ls_we), .ls_addr(z_ls_addr), .ls_wdata(z_ls_wdata),
        .ls_ack(z_ls_ack), .ls_rdata(z_ls_rdata),
        .mar_wr_en(z_mar_wr_en), .mar_in(z_mar_in), .mar_re_en(z_mar_re_en),
        .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata),
        .busy(z_busy)
    );

    // Environment: MAR register and memory array, with a backdoor load port.
    logic [DW-1:0] mem_array [1 << AW];
    logic [AW-1:0] mar_reg = '0, mar_out = '0;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (mar_wr_en) mar_reg <= mar_in;
        if (mar_re_en) mar_out <= mar_reg;
        if (bd_we) mem_array[bd_addr] <= bd_data;
        else if (mem_wr) mem_array[mar_out] <= mem_wdata;
    end
    assign mem_rdata = mem_array[mar_out];

    // Reference memory contents as seen by completed transactions.
    logic [DW-1:0] ref_mem [1 << AW];
    int total = 0;
    int bad = 0;

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if_req = 1'b0; ls_req = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({if_ack, ls_ack, mar_wr_en, mar_re_en, mem_rd, mem_wr, busy} !== 7'b0) begin bad++; $display("FAIL reset_ctrl: got %b required 0", {if_ack, ls_ack, mar_wr_en, mar_re_en, mem_rd, mem_wr, busy}); end
        total++; if ({mar_in, mem_wdata, if_rdata, ls_rdata} !== '0) begin bad++; $display("FAIL reset_data: got %h required 0", {mar_in, mem_wdata, if_rdata, ls_rdata}); end
        total++; if (z_busy !== 1'b0) begin bad++; $display("FAIL reset_busy0: got %b required 0", z_busy); end
        rst = 1'b0;
    endtask

    task automatic test_fetch;
        preload(13'h0123, 16'hBEEF);
        if_req = 1'b1; if_addr = 13'h0123;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++; if (mar_wr_en !== (k == 1)) begin bad++; $display("FAIL fetch_mar_wr k=%0d: got %b required %b", k, mar_wr_en, k == 1); end
            total++; if (mar_re_en !== (k == 2)) begin bad++; $display("FAIL fetch_mar_re k=%0d: got %b required %b", k, mar_re_en, k == 2); end
            total++; if (mem_rd !== (k >= 3 && k <= 5)) begin bad++; $display("FAIL fetch_mem_rd k=%0d: got %b", k, mem_rd); end
            total++; if (if_ack !== (k == 6)) begin bad++; $display("FAIL fetch_ack k=%0d: got %b required %b", k, if_ack, k == 6); end
            if (k == 1) begin total++; if (mar_in !== 13'h0123) begin bad++; $display("FAIL fetch_mar_in: got %h required 0123", mar_in); end end
            if (k == 6) begin
                total++; if (if_rdata !== 16'hBEEF) begin bad++; $display("FAIL fetch_rdata: got %h required beef", if_rdata); end
                if_req = 1'b0;
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fetch_idle: busy got %b required 0", busy); end
    endtask

    task automatic test_store;
        logic [DW-1:0] prev;
        prev = ls_rdata;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 13'h1FFF; ls_wdata = 16'hA5A5;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++; if (mem_wr !== (k >= 3 && k <= 5)) begin bad++; $display("FAIL store_mem_wr k=%0d: got %b", k, mem_wr); end
            total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL store_mem_rd k=%0d: got %b required 0", k, mem_rd); end
            total++; if (ls_ack !== (k == 6)) begin bad++; $display("FAIL store_ack k=%0d: got %b required %b", k, ls_ack, k == 6); end
            total++; if (ls_rdata !== prev) begin bad++; $display("FAIL store_rdata k=%0d: got %h required %h", k, ls_rdata, prev); end
            if (mem_wr) begin total++; if (mem_wdata !== 16'hA5A5) begin bad++; $display("FAIL store_wdata: got %h required a5a5", mem_wdata); end end
            if (k == 6) begin ls_req = 1'b0; ls_we = 1'b0; end
        end
        ref_mem[13'h1FFF] = 16'hA5A5;
    endtask

    task automatic test_tie;
        test_reset();
        if_req = 1'b1; if_addr = 13'h0123;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 13'h1FFF;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            total++; if (if_ack !== (k == 6)) begin bad++; $display("FAIL tie_if_ack k=%0d: got %b", k, if_ack); end
            total++; if (ls_ack !== (k == 13)) begin bad++; $display("FAIL tie_ls_ack k=%0d: got %b", k, ls_ack); end
            if (k == 8) begin
                total++; if (mar_wr_en !== 1'b1 || mar_in !== 13'h1FFF) begin bad++; $display("FAIL tie_ls_load: got en=%b addr=%h required en=1 addr=1fff", mar_wr_en, mar_in); end
            end
            if (if_ack) begin
                total++; if (if_rdata !== ref_mem[13'h0123]) begin bad++; $display("FAIL tie_if_rdata: got %h required %h", if_rdata, ref_mem[13'h0123]); end
                if_req = 1'b0;
            end
            if (ls_ack) begin
                total++; if (ls_rdata !== ref_mem[13'h1FFF]) begin bad++; $display("FAIL tie_ls_rdata: got %h required %h", ls_rdata, ref_mem[13'h1FFF]); end
                ls_req = 1'b0;
            end
        end
    endtask

    task automatic test_alternate;
        int order;
        int acks;
        order = 0; acks = 0;
        if_req = 1'b1; if_addr = 13'h0123;
        for (int k = 1; k <= 10 && if_req; k++) begin
            @(negedge clk);
            if (if_ack) if_req = 1'b0;
        end
        total++; if (if_req !== 1'b0) begin bad++; $display("FAIL alt_first_fetch: no ack got req=%b required 0", if_req); end
        if_req = 1'b0;
        @(negedge clk);
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 13'h1FFF;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ls_ack) begin acks++; if (order == 0) order = 1; ls_req = 1'b0; end
            if (if_ack) begin acks++; if (order == 0) order = 2; if_req = 1'b0; end
        end
        total++; if (order !== 1) begin bad++; $display("FAIL alt_order: first winner got %0d required 1 (load/store)", order); end
        total++; if (acks !== 2) begin bad++; $display("FAIL alt_acks: got %0d required 2", acks); end
    endtask

    task automatic test_wait0;
        int rd_cycles;
        rd_cycles = 0;
        z_ls_req = 1'b1; z_ls_we = 1'b0; z_ls_addr = 13'h0000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (z_mem_rd) rd_cycles++;
            total++; if (z_mar_wr_en !== (k == 1)) begin bad++; $display("FAIL w0_mar_wr k=%0d: got %b", k, z_mar_wr_en); end
            total++; if (z_ls_ack !== (k == 4)) begin bad++; $display("FAIL w0_ack k=%0d: got %b required %b", k, z_ls_ack, k == 4); end
            if (k == 4) begin
                total++; if (z_ls_rdata !== 16'h1234) begin bad++; $display("FAIL w0_rdata: got %h required 1234", z_ls_rdata); end
                z_ls_req = 1'b0;
            end
        end
        total++; if (rd_cycles !== 1) begin bad++; $display("FAIL w0_rd_cycles: got %0d required 1", rd_cycles); end
    endtask

    task automatic test_reset_mid;
        if_req = 1'b1; if_addr = 13'h0123;
        repeat (4) @(negedge clk);
        total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL rmid_in_access: mem_rd got %b required 1", mem_rd); end
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        total++; if ({if_ack, ls_ack, mar_wr_en, mar_re_en, mem_rd, mem_wr, busy} !== 7'b0) begin bad++; $display("FAIL rmid_ctrl: got %b required 0", {if_ack, ls_ack, mar_wr_en, mar_re_en, mem_rd, mem_wr, busy}); end
        total++; if ({mar_in, mem_wdata, if_rdata, ls_rdata} !== '0) begin bad++; $display("FAIL rmid_data: got %h required 0", {mar_in, mem_wdata, if_rdata, ls_rdata}); end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++; if (if_ack || ls_ack || busy) begin bad++; $display("FAIL rmid_quiet k=%0d: got ack=%b%b busy=%b required 0", k, if_ack, ls_ack, busy); end
        end
        if_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            total++; if (if_ack !== (k == 6)) begin bad++; $display("FAIL rmid_fresh_ack k=%0d: got %b", k, if_ack); end
            if (k == 6) begin
                total++; if (if_rdata !== 16'hBEEF) begin bad++; $display("FAIL rmid_fresh_rdata: got %h required beef", if_rdata); end
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_drop;
        int acks;
        acks = 0;
        if_req = 1'b1; if_addr = 13'h0123;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) if_req = 1'b0;
            if (if_ack) begin
                acks++;
                total++; if (k !== 6) begin bad++; $display("FAIL drop_ack_cycle: got %0d required 6", k); end
            end
        end
        total++; if (acks !== 1) begin bad++; $display("FAIL drop_ack_count: got %0d required 1", acks); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle: busy got %b required 0", busy); end
    endtask

    task automatic test_random;
        logic          pend_if, pend_ls, we_l;
        logic [AW-1:0] a_if, a_ls;
        logic [DW-1:0] wd_l;
        int age_if, age_ls, done, stop;
        pend_if = 1'b0; pend_ls = 1'b0; we_l = 1'b0; a_if = '0; a_ls = '0; wd_l = '0;
        age_if = 0; age_ls = 0; done = 0; stop = 0;
        for (int i = 0; i < 16; i++) preload(13'h0400 + 13'(i), 16'($urandom));
        for (int c = 0; c < 3000 && done < 60 && stop == 0; c++) begin
            @(negedge clk);
            total++; if (mar_wr_en && mar_re_en) begin bad++; $display("FAIL rnd_mar_excl: got both enables high"); end
            total++; if (mem_rd && mem_wr) begin bad++; $display("FAIL rnd_strobe_excl: got both strobes high"); end
            if (mem_wr) begin total++; if (!pend_ls || !we_l || mem_wdata !== wd_l) begin bad++; $display("FAIL rnd_wdata: got %h required %h", mem_wdata, wd_l); end end
            if (if_ack) begin
                total++;
                if (!pend_if) begin bad++; $display("FAIL rnd_if_spurious: got ack required none"); end
                else if (if_rdata !== ref_mem[a_if]) begin bad++; $display("FAIL rnd_if_rdata: got %h required %h", if_rdata, ref_mem[a_if]); end
                pend_if = 1'b0; if_req = 1'b0; done++;
            end
            if (ls_ack) begin
                total++;
                if (!pend_ls) begin bad++; $display("FAIL rnd_ls_spurious: got ack required none"); end
                else if (we_l) ref_mem[a_ls] = wd_l;
                else if (ls_rdata !== ref_mem[a_ls]) begin bad++; $display("FAIL rnd_ls_rdata: got %h required %h", ls_rdata, ref_mem[a_ls]); end
                pend_ls = 1'b0; ls_req = 1'b0; done++;
            end
            if (pend_if) age_if++;
            if (pend_ls) age_ls++;
            if (age_if > 2 * (5 + WAIT) || age_ls > 2 * (5 + WAIT)) begin
                total++; bad++; stop = 1;
                $display("FAIL rnd_timeout: got age if=%0d ls=%0d required <= %0d", age_if, age_ls, 2 * (5 + WAIT));
            end
            if (!pend_if && ($urandom % 3) == 0) begin
                pend_if = 1'b1; age_if = 0; a_if = 13'h0400 + 13'($urandom % 16);
                if_req = 1'b1; if_addr = a_if;
            end
            if (!pend_ls && ($urandom % 3) == 0) begin
                pend_ls = 1'b1; age_ls = 0; a_ls = 13'h0400 + 13'($urandom % 16);
                we_l = 1'($urandom % 2); wd_l = 16'($urandom);
                ls_req = 1'b1; ls_we = we_l; ls_addr = a_ls; ls_wdata = wd_l;
            end
        end
        total++; if (done < 60) begin bad++; $display("FAIL rnd_completed: got %0d required 60", done); end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_tie();
        test_alternate();
        test_wait0();
        test_reset_mid();
        test_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
